// File: rtl/matrix_row_streamer_pkg.sv
// Shared constants and FSM encoding for the matrix row streamer.
// Default geometry: 8x8 matrix of 32-bit words in a 128-entry RAM.
package matrix_row_streamer_pkg;

    localparam int MRS_WORD_LEN  = 32;
    localparam int MRS_DIM       = 8;
    localparam int MRS_ADDR_BITS = 7;

    typedef enum logic [2:0] {
        MRS_LOAD    = 3'd0,
        MRS_FULL    = 3'd1,
        MRS_RD_ADDR = 3'd2,
        MRS_RD_CAP  = 3'd3,
        MRS_RD_OUT  = 3'd4
    } mrs_state_e;

endpackage

// File: rtl/matrix_row_streamer.sv
// Loads a DIM x DIM matrix word by word into a parallel-row RAM,
// then streams it back one full row per RAM access.
module matrix_row_streamer
    import matrix_row_streamer_pkg::*;
#(
    parameter int WORD_LEN  = MRS_WORD_LEN,
    parameter int DIM       = MRS_DIM,
    parameter int ADDR_BITS = MRS_ADDR_BITS,
    parameter int BASE_ADDR = 0,
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_LEN-1:0]     s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    rd_start,
    output logic [WORD_LEN-1:0]     ram_data,
    output logic [ADDR_BITS-1:0]    ram_addr,
    output logic                    ram_we,
    input  logic [WORD_LEN*DIM-1:0] ram_q,
    output logic [WORD_LEN*DIM-1:0] row_data,
    output logic [RW-1:0]           row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    load_done
);

    localparam int CW        = $clog2(DIM * DIM) + 1;
    localparam int LAST_WORD = DIM * DIM - 1;

    if (BASE_ADDR + DIM * DIM - 1 > 2 ** ADDR_BITS - 1) begin : g_addr_range
        $error("matrix_row_streamer: matrix does not fit in RAM");
    end

    mrs_state_e                state_q, state_d;
    logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
    logic [RW-1:0]             row_q, row_d;
    logic                      ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0]      ram_addr_q, ram_addr_d;
    logic [WORD_LEN-1:0]       ram_data_q, ram_data_d;
    logic [WORD_LEN*DIM-1:0]   row_data_q, row_data_d;
    logic [RW-1:0]             row_idx_q, row_idx_d;
    logic                      row_valid_q, row_valid_d;
    logic                      load_done_q, load_done_d;

    function automatic logic [ADDR_BITS-1:0] row_addr(input logic [RW-1:0] r);
        return ADDR_BITS'(BASE_ADDR + int'(r) * DIM);
    endfunction

    // The row address is issued on entry to RD_ADDR and held through
    // RD_CAP, so a registered-address RAM has q ready for the capture.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        row_d       = row_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        row_data_d  = row_data_q;
        row_idx_d   = row_idx_q;
        row_valid_d = row_valid_q;
        load_done_d = load_done_q;
        unique case (state_q)
            MRS_LOAD: begin
                if (s_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = ADDR_BITS'(BASE_ADDR + int'(wr_cnt_q));
                    ram_data_d = s_data;
                    wr_cnt_d   = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(LAST_WORD)) begin
                        state_d     = MRS_FULL;
                        load_done_d = 1'b1;
                    end
                end
            end
            MRS_FULL: begin
                if (rd_start) begin
                    state_d    = MRS_RD_ADDR;
                    row_d      = '0;
                    ram_addr_d = row_addr('0);
                end
            end
            MRS_RD_ADDR: begin
                ram_addr_d = row_addr(row_q);
                state_d    = MRS_RD_CAP;
            end
            MRS_RD_CAP: begin
                row_data_d  = ram_q;
                row_idx_d   = row_q;
                row_valid_d = 1'b1;
                state_d     = MRS_RD_OUT;
            end
            MRS_RD_OUT: begin
                if (row_valid_q && row_ready) begin
                    row_valid_d = 1'b0;
                    if (row_q == RW'(DIM - 1)) begin
                        state_d     = MRS_LOAD;
                        load_done_d = 1'b0;
                        wr_cnt_d    = '0;
                    end else begin
                        row_d      = row_q + RW'(1);
                        ram_addr_d = row_addr(row_q + RW'(1));
                        state_d    = MRS_RD_ADDR;
                    end
                end
            end
            default: state_d = MRS_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MRS_LOAD;
            wr_cnt_q    <= '0;
            row_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
            row_valid_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            row_q       <= row_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            row_data_q  <= row_data_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
            load_done_q <= load_done_d;
        end
    end

    assign s_ready   = (state_q == MRS_LOAD);
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign row_data  = row_data_q;
    assign row_idx   = row_idx_q;
    assign row_valid = row_valid_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_matrix_row_streamer.sv
// Scoreboard bench for matrix_row_streamer with a behavioural
// parallel-row RAM (sync write, registered read address).
module tb_matrix_row_streamer;

    localparam int WL  = 32;
    localparam int DIM = 8;
    localparam int AB  = 7;
    localparam int NW  = DIM * DIM;

    typedef struct {
        logic [AB-1:0] a;
        logic [WL-1:0] d;
    } wr_t;

    typedef struct {
        logic [2:0]        idx;
        logic [WL*DIM-1:0] d;
    } row_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WL-1:0]     s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              rd_start = 1'b0;
    logic [WL-1:0]     ram_data;
    logic [AB-1:0]     ram_addr;
    logic              ram_we;
    logic [WL*DIM-1:0] ram_q;
    logic [WL*DIM-1:0] row_data;
    logic [2:0]        row_idx;
    logic              row_valid;
    logic              row_ready = 1'b1;
    logic              load_done;

    int n_cmp = 0;
    int n_bad = 0;

    wr_t   wq[$];
    row_t  rq[$];
    logic [WL-1:0] model[NW];

    logic [WL-1:0] mem[2**AB];
    logic [AB-1:0] addr_r = '0;

    always #5 clk = ~clk;

    matrix_row_streamer dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rd_start(rd_start),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_q(ram_q),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .load_done(load_done)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        addr_r <= ram_addr;
    end

    always_comb begin
        ram_q = '0;
        for (int k = 0; k < DIM; k++)
            ram_q[k*WL +: WL] = mem[(int'(addr_r) + k) % (2**AB)];
    end

    task automatic chk(input string tag, input logic [WL*DIM-1:0] got,
                       input logic [WL*DIM-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: writes and presented rows against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", ram_addr, e.a);
                    chk("wr_data", ram_data, e.d);
                end
            end
            if (row_valid) begin
                if (rq.size() == 0) chk("row_unexpected", 1, 0);
                else begin
                    chk("row_idx", row_idx, rq[0].idx);
                    chk("row_data", row_data, rq[0].d);
                    chk("row_addr_held", ram_addr, AB'(int'(rq[0].idx) * DIM));
                    chk("row_no_we", ram_we, 0);
                    if (row_ready) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic load(input logic [WL-1:0] base, input bit gaps,
                        input int pulse_at);
        int c = 0;
        for (int i = 0; i < NW; i++) begin
            if (gaps && (c % 3 == 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
                chk("gap_we", ram_we, 0);
                c++;
            end
            s_valid = 1'b1;
            s_data  = base + WL'(i);
            rd_start = (i == pulse_at);
            model[i] = s_data;
            wq.push_back('{a: AB'(i), d: s_data});
            if (i == NW - 1) chk("done_before_last", load_done, 0);
            @(posedge clk); #1;
            rd_start = 1'b0;
            c++;
        end
        s_valid = 1'b0;
        chk("load_done", load_done, 1);
        chk("s_ready_full", s_ready, 0);
    endtask

    task automatic read(input int stall_row, input int stall_len,
                        input int rst_row);
        int n = 0;
        int vcnt = 0;
        int left = stall_len;
        for (int r = 0; r < DIM; r++) begin
            row_t e;
            e.idx = 3'(r);
            for (int k = 0; k < DIM; k++)
                e.d[k*WL +: WL] = model[r*DIM + k];
            rq.push_back(e);
        end
        rd_start = 1'b1;
        @(posedge clk); #1;
        rd_start = 1'b0;
        while (load_done && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (row_valid) vcnt++;
            if (rst_row >= 0 && row_valid && int'(row_idx) == rst_row) begin
                row_ready = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_row_valid", row_valid, 0);
                chk("rst_load_done", load_done, 0);
                chk("rst_s_ready", s_ready, 1);
                chk("rst_we", ram_we, 0);
                rst = 1'b0;
                rq.delete();
                row_ready = 1'b1;
                return;
            end
            if (row_valid && int'(row_idx) == stall_row && left > 0) begin
                row_ready = 1'b0;
                left--;
            end else begin
                row_ready = 1'b1;
            end
        end
        row_ready = 1'b1;
        chk("rd_cycles", n, 24 + stall_len);
        chk("valid_cycles", vcnt, 8 + stall_len);
        chk("back_to_load", s_ready, 1);
        chk("rows_left", rq.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_idx", row_idx, 0);
        rst = 1'b0;

        load(32'h0, 1'b0, -1);
        read(-1, 0, -1);

        load(32'h1000, 1'b1, -1);
        read(-1, 0, -1);

        load(32'h2000, 1'b0, -1);
        read(3, 5, -1);

        load(32'h3000, 1'b0, 10);
        s_valid = 1'b1;
        s_data  = 32'hdead_beef;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("full_hold_done", load_done, 1);
        chk("full_no_row", row_valid, 0);
        chk("full_s_ready", s_ready, 0);
        read(-1, 0, -1);

        load(32'h4000, 1'b0, -1);
        read(-1, 0, 5);
        load(32'h5000, 1'b0, -1);
        read(-1, 0, -1);

        repeat (2) @(posedge clk);
        #1;
        chk("wr_left", wq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
